// File: rtl/led_share_arbiter.sv
// led_share_arbiter: round-robin sharing of one status LED (blink burst + gap per grant); define LED_SHARE_IDLE_HEARTBEAT_EN for an idle heartbeat.
// Latency: all outputs registered, grant one cycle after IDLE sampling; no backpressure, req is a level held by the requester.
module led_share_arbiter #(
    parameter int N_REQ     = 4,
    parameter int CLK_DIV   = 12000000,
    parameter int GAP_TICKS = 24000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] cnt,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic               led
);
    localparam int          PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [31:0] DIV_LAST = 32'(CLK_DIV - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP_TICKS - 1);

    typedef enum logic [2:0] {S_IDLE, S_ON, S_OFF, S_GAP, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]    gidx, gidx_nxt;
    logic [3:0]       bc, bc_nxt;
    logic [31:0]      tick;
    logic             found;
    logic [PW-1:0]    pick, cand;
    logic [3:0]       sel_cnt;
    logic [N_REQ-1:0] onehot;
    logic [N_REQ-1:0] gnt_nxt, done_nxt;
    logic             busy_nxt, led_nxt;
    logic             hb_nxt;

`ifdef LED_SHARE_IDLE_HEARTBEAT_EN
    logic [31:0] hb_cnt;
    logic        hb_lvl;

    assign hb_nxt = (hb_cnt == DIV_LAST) ? ~hb_lvl : hb_lvl;

    always_ff @(posedge clk) begin
        if (reset) begin
            hb_cnt <= '0;
            hb_lvl <= 1'b0;
        end else begin
            hb_cnt <= (hb_cnt == DIV_LAST) ? '0 : hb_cnt + 32'd1;
            hb_lvl <= hb_nxt;
        end
    end
`else
    assign hb_nxt = 1'b0;
`endif

    // First set request at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PW'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        sel_cnt = 4'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == PW'(i)) sel_cnt = cnt[4*i +: 4];
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        gidx_nxt   = gidx;
        bc_nxt     = bc;
        case (state)
            S_IDLE: begin
                if (found) begin
                    gidx_nxt   = pick;
                    bc_nxt     = sel_cnt;
                    rr_ptr_nxt = PW'((int'(pick) + 1) % N_REQ);
                    state_nxt  = (sel_cnt != 4'd0) ? S_ON : S_GAP;
                end
            end
            S_ON: begin
                if (tick == DIV_LAST) state_nxt = S_OFF;
            end
            S_OFF: begin
                if (tick == DIV_LAST) begin
                    bc_nxt    = bc - 4'd1;
                    state_nxt = (bc != 4'd1) ? S_ON : S_GAP;
                end
            end
            S_GAP: begin
                if (tick == GAP_LAST) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are precomputed from the next state so they can be registered.
        onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            onehot[i] = (gidx_nxt == PW'(i));
        end
        gnt_nxt  = '0;
        done_nxt = '0;
        busy_nxt = 1'b0;
        led_nxt  = 1'b0;
        case (state_nxt)
            S_ON: begin
                gnt_nxt  = onehot;
                busy_nxt = 1'b1;
                led_nxt  = 1'b1;
            end
            S_OFF, S_GAP: begin
                gnt_nxt  = onehot;
                busy_nxt = 1'b1;
            end
            S_DONE: begin
                done_nxt = onehot;
                led_nxt  = hb_nxt;
            end
            default: led_nxt = hb_nxt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            gidx   <= '0;
            bc     <= '0;
            tick   <= '0;
            gnt    <= '0;
            done   <= '0;
            busy   <= 1'b0;
            led    <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            gidx   <= gidx_nxt;
            bc     <= bc_nxt;
            tick   <= (state_nxt != state || state == S_IDLE) ? '0 : tick + 32'd1;
            gnt    <= gnt_nxt;
            done   <= done_nxt;
            busy   <= busy_nxt;
            led    <= led_nxt;
        end
    end
endmodule

// File: tb/tb_led_share_arbiter.sv
// Bench for led_share_arbiter: vector table, directed multi-cycle sequences, and random traffic against a service-schedule model.
module tb_led_share_arbiter;
    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int GAP = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [4*N-1:0] cnt = '0;
    logic [N-1:0]  gnt, done;
    logic          busy, led;

    int errors = 0;
    int checks = 0;
    int hb_cyc = 0;

    led_share_arbiter #(.N_REQ(N), .CLK_DIV(DIV), .GAP_TICKS(GAP)) dut (
        .clk(clk), .reset(reset), .req(req), .cnt(cnt),
        .gnt(gnt), .done(done), .busy(busy), .led(led)
    );

    always #5 clk = ~clk;

    // Cycles since the last reset edge; the heartbeat level is derived from it.
    always @(posedge clk) begin
        if (reset) hb_cyc <= 0;
        else       hb_cyc <= hb_cyc + 1;
    end

    function automatic logic hb_exp();
`ifdef LED_SHARE_IDLE_HEARTBEAT_EN
        return ((hb_cyc / DIV) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    // el: 0/1 literal LED level, 2 = idle/done level (heartbeat or 0)
    task automatic chk(input string nm, input logic [N-1:0] eg, input logic [N-1:0] ed,
                       input logic eb, input logic [1:0] el);
        logic le;
        le = (el == 2'd2) ? hb_exp() : el[0];
        checks++;
        if (gnt !== eg || done !== ed || busy !== eb || led !== le) begin
            errors++;
            $display("FAIL %s t=%0t actual gnt=%b done=%b busy=%b led=%b required gnt=%b done=%b busy=%b led=%b",
                     nm, $time, gnt, done, busy, led, eg, ed, eb, le);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        cnt   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [4*N-1:0] cnt;
        logic [N-1:0]   gnt;
        logic [N-1:0]   done;
        logic           busy;
        logic [1:0]     led;
    } vec_t;

    typedef struct {
        bit           idle;
        logic [N-1:0] gnt;
        logic [N-1:0] done;
        logic         busy;
        logic [1:0]   led;
    } rec_t;

    vec_t vt[13];
    rec_t exp_q[$];
    rec_t cur, r;
    int   rr, w, n, c;
    bit   fnd;
    logic [N-1:0] eg, ed;
    logic [1:0]   el;
    int   p, s;

    initial begin
        // Reset, zero-count services, round-robin pointer, no arbitration in DONE.
        vt[0]  = '{1'b1, 4'b1111, 16'h1111, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vt[1]  = '{1'b1, 4'b1111, 16'h1111, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vt[2]  = '{1'b0, 4'b0010, 16'h0000, 4'b0010, 4'b0000, 1'b1, 2'd0};
        vt[3]  = '{1'b0, 4'b0000, 16'h0000, 4'b0010, 4'b0000, 1'b1, 2'd0};
        vt[4]  = '{1'b0, 4'b0000, 16'h0000, 4'b0010, 4'b0000, 1'b1, 2'd0};
        vt[5]  = '{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0010, 1'b0, 2'd2};
        vt[6]  = '{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 2'd2};
        vt[7]  = '{1'b0, 4'b1010, 16'h0000, 4'b1000, 4'b0000, 1'b1, 2'd0};
        vt[8]  = '{1'b0, 4'b0000, 16'h0000, 4'b1000, 4'b0000, 1'b1, 2'd0};
        vt[9]  = '{1'b0, 4'b0000, 16'h0000, 4'b1000, 4'b0000, 1'b1, 2'd0};
        vt[10] = '{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b1000, 1'b0, 2'd2};
        vt[11] = '{1'b0, 4'b0011, 16'h0000, 4'b0000, 4'b0000, 1'b0, 2'd2};
        vt[12] = '{1'b0, 4'b0011, 16'h0000, 4'b0001, 4'b0000, 1'b1, 2'd0};

        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            reset = vt[i].rst;
            req   = vt[i].req;
            cnt   = vt[i].cnt;
            step();
            chk($sformatf("vec%0d", i), vt[i].gnt, vt[i].done, vt[i].busy, vt[i].led);
        end

        // Single request, count 2 on requester 2, held through a regrant.
        do_reset();
        req = 4'b0100;
        cnt = 16'h0200;
        for (int k = 1; k <= 22; k++) begin
            step();
            eg = (k <= 19 || k == 22) ? 4'b0100 : 4'b0000;
            ed = (k == 20) ? 4'b0100 : 4'b0000;
            if ((k >= 1 && k <= 4) || (k >= 9 && k <= 12) || k == 22) el = 2'd1;
            else if (k == 20 || k == 21)                               el = 2'd2;
            else                                                      el = 2'd0;
            chk($sformatf("single_c%0d", k), eg, ed, eg != 0, el);
        end

        // Reset in the middle of a count-3 service.
        do_reset();
        req = 4'b0100;
        cnt = 16'h0300;
        repeat (6) step();
        chk("midrst_c6", 4'b0100, 4'b0000, 1'b1, 2'd0);
        reset = 1'b1;
        step();
        chk("midrst_c7", 4'b0000, 4'b0000, 1'b0, 2'd0);
        reset = 1'b0;
        req   = 4'b1010;
        step();
        chk("midrst_regrant", 4'b0010, 4'b0000, 1'b1, 2'd0);

        // Round robin: all requesting, count 1 each; 13-cycle period per service.
        do_reset();
        req = 4'b1111;
        cnt = 16'h1111;
        for (int k = 1; k <= 65; k++) begin
            step();
            p = (k - 1) % 13;
            s = (k - 1) / 13;
            eg = (p <= 10) ? 4'(1 << (s % N)) : 4'b0000;
            ed = (p == 11) ? 4'(1 << (s % N)) : 4'b0000;
            el = (p <= 3) ? 2'd1 : (p >= 11) ? 2'd2 : 2'd0;
            chk($sformatf("rr_c%0d", k), eg, ed, p <= 10, el);
        end

        // Idle LED: heartbeat in that build, dark otherwise.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("idle_c%0d", k), 4'b0000, 4'b0000, 1'b0, 2'd2);
        end

        // Random traffic against a schedule model: each grant expands into
        // 2*n*DIV blink cycles, GAP dark cycles and one DONE cycle.
        do_reset();
        rr  = 0;
        cur = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2};
        for (int t = 0; t < 3000; t++) begin
            chk("rand", cur.gnt, cur.done, cur.busy, cur.led);
            req = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                cnt[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                            : 4'($urandom_range(0, 2));
            end
            if (cur.idle && req != 0) begin
                fnd = 1'b0;
                w   = 0;
                for (int k = 0; k < N; k++) begin
                    c = (rr + k) % N;
                    if (!fnd && req[c]) begin
                        fnd = 1'b1;
                        w   = c;
                    end
                end
                n  = int'(cnt[4*w +: 4]);
                rr = (w + 1) % N;
                for (int j = 0; j < 2 * n * DIV; j++) begin
                    r = '{1'b0, 4'(1 << w), 4'b0000, 1'b1, ((j / DIV) % 2 == 0) ? 2'd1 : 2'd0};
                    exp_q.push_back(r);
                end
                for (int j = 0; j < GAP; j++) begin
                    r = '{1'b0, 4'(1 << w), 4'b0000, 1'b1, 2'd0};
                    exp_q.push_back(r);
                end
                r = '{1'b0, 4'b0000, 4'(1 << w), 1'b0, 2'd2};
                exp_q.push_back(r);
            end
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2};
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t actual still running required finished", $time);
        $fatal(1, "watchdog");
    end
endmodule
